// File: rtl/rv_plic_claim_arb.sv
`default_nettype none
// ============================================================================
// Module   : rv_plic_claim_arb
// Purpose  : PLIC claim/complete arbiter. Round-robin claim serialization
//            across targets, in-service tracking, gateway claim/complete pulses.
// Revision : 1.0
// ============================================================================
module rv_plic_claim_arb #(
    parameter  int N_SOURCE = 32,
    parameter  int N_TARGET = 2,
    localparam int SrcWidth = $clog2(N_SOURCE),
    localparam int TgtWidth = (N_TARGET > 1) ? $clog2(N_TARGET) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [N_TARGET-1:0]                 claim_req_i,
    input  logic [N_TARGET-1:0][SrcWidth-1:0]   target_id_i,
    output logic [N_TARGET-1:0]                 claim_ack_o,
    output logic [N_TARGET-1:0][SrcWidth-1:0]   claim_id_o,
    input  logic [N_TARGET-1:0]                 complete_we_i,
    input  logic [N_TARGET-1:0][SrcWidth-1:0]   complete_id_i,
    output logic [N_SOURCE-1:0]                 claim_o,
    output logic [N_SOURCE-1:0]                 complete_o,
    output logic [N_SOURCE-1:0]                 inservice_o
);

    logic [N_TARGET-1:0]               claim_ack_q, claim_ack_d;
    logic [N_TARGET-1:0][SrcWidth-1:0] claim_id_q,  claim_id_d;
    logic [N_SOURCE-1:0]               claim_q,     claim_d;
    logic [N_SOURCE-1:0]               complete_q,  complete_d;
    logic [N_SOURCE-1:0]               inservice_q, inservice_d;
    logic [TgtWidth-1:0]               ptr_q,       ptr_d;

    logic [N_TARGET-1:0] eff_req;
    logic                found, found_hi, found_lo;
    logic [TgtWidth-1:0] winner, win_hi, win_lo;
    logic [SrcWidth-1:0] win_id;
    logic                claim_ok;
    logic [N_SOURCE-1:0] clm_mask, cmp_mask;

    // A requester is ignored in its own ack cycle so a held req cannot double-claim.
    assign eff_req = claim_req_i & ~claim_ack_q;

    // Descending scan leaves the lowest index at/above ptr in win_hi, and the
    // lowest index below ptr in win_lo; win_hi takes precedence (wrap order).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        win_hi   = '0;
        win_lo   = '0;
        for (int t = N_TARGET - 1; t >= 0; t--) begin
            if (eff_req[t]) begin
                if (TgtWidth'(t) >= ptr_q) begin
                    found_hi = 1'b1;
                    win_hi   = TgtWidth'(t);
                end else begin
                    found_lo = 1'b1;
                    win_lo   = TgtWidth'(t);
                end
            end
        end
        found  = found_hi | found_lo;
        winner = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        win_id   = target_id_i[winner];
        claim_ok = found && (win_id != '0) && (int'(win_id) < N_SOURCE)
                   && !inservice_q[win_id];
        clm_mask = '0;
        if (claim_ok) begin
            clm_mask[win_id] = 1'b1;
        end
    end

    // Completions are unarbitrated; duplicates collapse into one mask bit.
    always_comb begin
        cmp_mask = '0;
        for (int s = 1; s < N_SOURCE; s++) begin
            for (int t = 0; t < N_TARGET; t++) begin
                if (complete_we_i[t] && (complete_id_i[t] == SrcWidth'(s))) begin
                    cmp_mask[s] = 1'b1;
                end
            end
        end
        cmp_mask = cmp_mask & inservice_q;
    end

    always_comb begin
        claim_ack_d = '0;
        claim_id_d  = '0;
        ptr_d       = ptr_q;
        if (found) begin
            claim_ack_d[winner] = 1'b1;
            if (claim_ok) begin
                claim_id_d[winner] = win_id;
            end
            ptr_d = (int'(winner) == N_TARGET - 1) ? '0 : winner + TgtWidth'(1);
        end
        claim_d     = clm_mask;
        complete_d  = cmp_mask;
        inservice_d = (inservice_q & ~cmp_mask) | clm_mask;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            claim_ack_q <= '0;
            claim_id_q  <= '0;
            claim_q     <= '0;
            complete_q  <= '0;
            inservice_q <= '0;
            ptr_q       <= '0;
        end else begin
            claim_ack_q <= claim_ack_d;
            claim_id_q  <= claim_id_d;
            claim_q     <= claim_d;
            complete_q  <= complete_d;
            inservice_q <= inservice_d;
            ptr_q       <= ptr_d;
        end
    end

    assign claim_ack_o = claim_ack_q;
    assign claim_id_o  = claim_id_q;
    assign claim_o     = claim_q;
    assign complete_o  = complete_q;
    assign inservice_o = inservice_q;

endmodule
`default_nettype wire
